// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU path vs a
// buffered load path, plus a pending-write scoreboard for decode hazard checks.
module regfile_wb_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wa,
    input  logic [DW-1:0] alu_wd,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_wa,
    input  logic [DW-1:0] mem_wd,
    output logic          mem_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          haz1,
    output logic          haz2,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2 ** AW;

    logic [AW-1:0]   fifo_wa [FIFO_DEPTH];
    logic [DW-1:0]   fifo_wd [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rr_fifo;
    logic [NREG-1:0] pending, pending_nxt;

    logic            full, empty, push, pop, alu_sel, grant, contested;
    logic [AW-1:0]   sel_wa;
    logic [DW-1:0]   sel_wd;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = mem_valid && !full;
    assign contested = alu_valid && !empty;
    // A full FIFO always beats the ALU so the load path never backs up.
    assign pop       = !empty && (!alu_valid || full || rr_fifo);
    assign alu_sel   = alu_valid && !pop;
    assign grant     = pop || alu_sel;
    assign sel_wa    = pop ? fifo_wa[rd_ptr] : alu_wa;
    assign sel_wd    = pop ? fifo_wd[rd_ptr] : alu_wd;

    assign alu_ready = alu_sel && !rst;
    assign mem_ready = !full;
    assign haz1      = pending[ra1];
    assign haz2      = pending[ra2];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= mem_wa;
            fifo_wd[wr_ptr] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr_fifo <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (contested) rr_fifo <= !pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= grant && (sel_wa != '0);
            if (grant) begin
                wa <= sel_wa;
                wd <= sel_wd;
            end
        end
    end

    // A new issue to a register overrides the retiring write of its older value.
    always_comb begin
        pending_nxt = pending;
        if (we) pending_nxt[wa] = 1'b0;
        if (iss_valid) pending_nxt[iss_wa] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: queue-based reference model, with
// expected register writes scoreboarded and checked by an independent monitor.
module tb_regfile_wb_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 0, mem_valid = 0, iss_valid = 0;
    logic [AW-1:0] alu_wa = 0, mem_wa = 0, iss_wa = 0, ra1 = 0, ra2 = 0;
    logic [DW-1:0] alu_wd = 0, mem_wd = 0;
    logic          alu_ready, mem_ready, haz1, haz2, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    regfile_wb_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_wa(iss_wa), .ra1(ra1), .ra2(ra2),
        .haz1(haz1), .haz2(haz2), .we(we), .wa(wa), .wd(wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    int   total = 0, bad = 0, cyc = 0;
    wr_t  mq[$];
    wr_t  exp_q[$];
    bit   pend [2**AW];
    bit   fav_fifo = 0;
    bit   alu_acc = 0;
    logic [AW-1:0] last_w = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
        end
    endtask

    // Monitor: compares the write port against the scoreboard every cycle.
    wr_t mon_w;
    bit  mon_due;
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            mon_due = exp_q.size() > 0 && exp_q[0].cyc == cyc;
            chk("we", we, mon_due);
            if (mon_due) begin
                mon_w = exp_q.pop_front();
                if (we) begin
                    chk("wa", wa, mon_w.wa);
                    chk("wd", wd, mon_w.wd);
                end
            end
        end
    end

    task automatic clear_model();
        mq.delete();
        exp_q.delete();
        foreach (pend[i]) pend[i] = 0;
        fav_fifo = 0;
        alu_acc  = 0;
        last_w   = 0;
    endtask

    task automatic step(input logic av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] mw, input logic [DW-1:0] md,
                        input logic iv, input logic [AW-1:0] iw,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit  full, tf, ta;
        wr_t w;
        @(negedge clk);
        alu_valid = av; alu_wa = aw; alu_wd = ad;
        mem_valid = mv; mem_wa = mw; mem_wd = md;
        iss_valid = iv; iss_wa = iw; ra1 = r1; ra2 = r2;
        #1;
        full = (mq.size() == DEPTH);
        if (av && mq.size() > 0) begin
            tf = full || fav_fifo;
            fav_fifo = !tf;
        end else begin
            tf = mq.size() > 0;
        end
        ta = av && !tf;
        chk("alu_ready", alu_ready, ta);
        chk("mem_ready", mem_ready, !full);
        chk("haz1", haz1, pend[r1]);
        chk("haz2", haz2, pend[r2]);
        alu_acc = ta;
        w = '{0, 0, 0};
        if (tf) w = mq.pop_front();
        else if (ta) begin w.wa = aw; w.wd = ad; end
        if (mv && !full) mq.push_back('{0, mw, md});
        if (w.wa != 0) begin w.cyc = cyc + 1; exp_q.push_back(w); end
        if (last_w != 0) pend[last_w] = 0;
        if (iv && iw != 0) pend[iw] = 1;
        last_w = w.wa;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic          h_av, h_mv, h_iv;
    logic [AW-1:0] h_aw, h_mw, h_iw, h_r1, h_r2;
    logic [DW-1:0] h_ad, h_md;

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        alu_valid = 1;
        #1 chk("alu_ready_in_rst", alu_ready, 0);
        alu_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_haz1", haz1, 0);
        chk("rst_haz2", haz2, 0);

        // Contention: both sources held valid, FIFO fills and wins ties when full.
        for (int i = 0; i < 8; i++) step(1, 11, 4, 1, 9, 32'hDEAD, 0, 0, 0, 0);
        idle(4);
        // ALU only, then r0 write and r0 issue.
        step(1, 9, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // Scoreboard: set, write-clear, set-wins-over-clear.
        step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(1, 5, 77, 0, 0, 0, 0, 0, 5, 5);
        step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(1, 5, 78, 0, 0, 0, 0, 0, 5, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

        // Fill the FIFO, then pulse reset between edges.
        for (int i = 0; i < 10; i++) begin
            step(1, 3, 33, 1, 4, 44, 1, 7, 7, 4);
            if (mq.size() == DEPTH) break;
        end
        @(negedge clk);
        alu_valid = 0; mem_valid = 0; iss_valid = 0; ra1 = 7; ra2 = 3;
        #2 rst = 1;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_mem_ready", mem_ready, 1);
        chk("mid_rst_haz1", haz1, 0);
        chk("mid_rst_haz2", haz2, 0);
        clear_model();
        #1 rst = 0;
        idle(4);

        // Random traffic; ALU source holds its request until accepted.
        h_av = 0; h_aw = 0; h_ad = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(h_av && !alu_acc)) begin
                h_av = 1'($urandom_range(0, 1));
                h_aw = AW'($urandom_range(0, 7));
                h_ad = $urandom;
            end
            h_mv = 1'($urandom_range(0, 1));
            h_mw = AW'($urandom_range(0, 7));
            h_md = $urandom;
            h_iv = 1'($urandom_range(0, 1));
            h_iw = AW'($urandom_range(0, 7));
            h_r1 = AW'($urandom_range(0, 7));
            h_r2 = AW'($urandom_range(0, 7));
            step(h_av, h_aw, h_ad, h_mv, h_mw, h_md, h_iv, h_iw, h_r1, h_r2);
        end
        idle(6);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
